// File: rtl/stream_ref_checker.sv
// rtl/stream_ref_checker.sv - expected-word FIFO with delayed capture and lane/element compare
//
// Purpose:
//    Buffers expected words pushed by a reader front end. On each observation
//    trigger it captures a DUT word after CAP_DELAY cycles, and selects one lane
//    of the FIFO head. It compares the two either over all elements or over the
//    first popcount(obs_flg) elements. It keeps saturating check/error counters,
//    first-mismatch diagnostics and sticky FIFO/config error flags.
//
// Ports:
//    clk            in   clock
//    rst_n          in   asynchronous active-low reset
//    clr            in   synchronous clear of FIFO, delay line, counters, flags
//    exp_push       in   push exp_dat into the FIFO
//    exp_dat        in   expected word, lane 0 in the MSBs
//    exp_full       out  FIFO full
//    exp_level      out  FIFO occupancy
//    obs_trig       in   observation event, enters the capture delay line
//    obs_dat        in   observed word, sampled at capture
//    obs_flg        in   element-valid flags, sampled at capture
//    lane_sel       in   lane index, sampled at capture
//    mode           in   0: all elements, 1: first popcount(obs_flg) elements
//    chk_done       out  one-cycle pulse, a compare completed
//    chk_err        out  one-cycle pulse with chk_done, compare mismatched
//    chk_cnt        out  completed compares, saturating
//    err_cnt        out  mismatching compares, saturating
//    first_err_idx  out  chk_cnt value of the first mismatching compare
//    first_err_elem out  lowest mismatching element of the first mismatch
//    ovf            out  sticky, push dropped while full
//    udf            out  sticky, capture with empty FIFO
//    cfg_err        out  sticky, capture with lane_sel >= NUM_LANES

module stream_ref_checker #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_ELEM   = 32,
   parameter int NUM_LANES  = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int CAP_DELAY  = 1,
   parameter int CNT_WIDTH  = 16,
   localparam int OBS_W  = DATA_WIDTH * NUM_ELEM,
   localparam int EXP_W  = OBS_W * NUM_LANES,
   localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1,
   localparam int LSEL_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
   localparam int ELEM_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic                 exp_push,
   input  logic [EXP_W-1:0]     exp_dat,
   output logic                 exp_full,
   output logic [LVL_W-1:0]     exp_level,
   input  logic                 obs_trig,
   input  logic [OBS_W-1:0]     obs_dat,
   input  logic [NUM_ELEM-1:0]  obs_flg,
   input  logic [LSEL_W-1:0]    lane_sel,
   input  logic                 mode,
   output logic                 chk_done,
   output logic                 chk_err,
   output logic [CNT_WIDTH-1:0] chk_cnt,
   output logic [CNT_WIDTH-1:0] err_cnt,
   output logic [CNT_WIDTH-1:0] first_err_idx,
   output logic [ELEM_W-1:0]    first_err_elem,
   output logic                 ovf,
   output logic                 udf,
   output logic                 cfg_err
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int PC_W  = $clog2(NUM_ELEM + 1);
   localparam logic [LVL_W-1:0]     FULL_LVL  = LVL_W'(FIFO_DEPTH);
   localparam logic [LSEL_W:0]      LANES_EXT = (LSEL_W + 1)'(NUM_LANES);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

   // ---------------------------------------------------------------
   // Trigger delay line
   // ---------------------------------------------------------------
   logic cap;

   generate
      if (CAP_DELAY == 0) begin : g_nodly
         assign cap = obs_trig;
      end else begin : g_dly
         logic [CAP_DELAY-1:0] trig_q;
         logic [CAP_DELAY-1:0] trig_d;

         always_comb begin
            trig_d = (trig_q << 1) | CAP_DELAY'(obs_trig);
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               trig_q <= '0;
            end else if (clr) begin
               trig_q <= '0;
            end else begin
               trig_q <= trig_d;
            end
         end

         assign cap = trig_q[CAP_DELAY-1];
      end
   endgenerate

   // ---------------------------------------------------------------
   // Expected-word FIFO storage (data array is not reset)
   // ---------------------------------------------------------------
   logic [EXP_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             fifo_empty;
   logic             fifo_full;
   logic             lane_bad;
   logic             pop;
   logic             push_ok;
   logic             do_cmp;
   logic [EXP_W-1:0] head;

   assign fifo_empty = (level_q == '0);
   assign fifo_full  = (level_q == FULL_LVL);
   assign head       = mem_q[rd_ptr_q];

   // A bad lane index still consumes the head so the stream stays aligned
   // with the DUT; an empty FIFO never pops and never sees a same-cycle push.
   assign lane_bad = ({1'b0, lane_sel} >= LANES_EXT);
   assign pop      = cap & ~fifo_empty;
   assign do_cmp   = cap & ~lane_bad & ~fifo_empty;
   assign push_ok  = exp_push & (~fifo_full | pop);

   always_ff @(posedge clk) begin
      if (push_ok && !clr) begin
         mem_q[wr_ptr_q] <= exp_dat;
      end
   end

   // ---------------------------------------------------------------
   // Lane select and element compare
   // ---------------------------------------------------------------
   logic [OBS_W-1:0]    lane_w;
   logic [PC_W-1:0]     pc;
   logic [NUM_ELEM-1:0] mism;
   logic                in_scope;
   logic [ELEM_W-1:0]   first_k;

   always_comb begin
      lane_w = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         if (lane_sel == LSEL_W'(l)) begin
            lane_w = head[OBS_W*(NUM_LANES-1-l) +: OBS_W];
         end
      end
   end

   always_comb begin
      pc = '0;
      for (int k = 0; k < NUM_ELEM; k++) begin
         pc = pc + PC_W'(obs_flg[k]);
      end
   end

   // In mode 1 only a prefix of length popcount(obs_flg) is compared, so the
   // flag positions themselves do not matter, only how many are set.
   always_comb begin
      mism     = '0;
      in_scope = 1'b0;
      for (int k = 0; k < NUM_ELEM; k++) begin
         in_scope = ~mode | (PC_W'(k) < pc);
         if (in_scope &&
             (obs_dat[DATA_WIDTH*k +: DATA_WIDTH] != lane_w[DATA_WIDTH*k +: DATA_WIDTH])) begin
            mism[k] = 1'b1;
         end
      end
   end

   always_comb begin
      first_k = '0;
      for (int k = NUM_ELEM - 1; k >= 0; k--) begin
         if (mism[k]) begin
            first_k = ELEM_W'(k);
         end
      end
   end

   // ---------------------------------------------------------------
   // Result stage, counters and sticky flags
   // ---------------------------------------------------------------
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic [CNT_WIDTH-1:0] chk_cnt_q, chk_cnt_d;
   logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
   logic [CNT_WIDTH-1:0] fidx_q, fidx_d;
   logic [ELEM_W-1:0]    felem_q, felem_d;
   logic                 ovf_q, ovf_d;
   logic                 udf_q, udf_d;
   logic                 cfg_q, cfg_d;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      level_d   = level_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      chk_cnt_d = chk_cnt_q;
      err_cnt_d = err_cnt_q;
      fidx_d    = fidx_q;
      felem_d   = felem_q;
      ovf_d     = ovf_q;
      udf_d     = udf_q;
      cfg_d     = cfg_q;

      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      level_d = level_q + LVL_W'(push_ok) - LVL_W'(pop);

      if (exp_push && fifo_full && !pop) begin
         ovf_d = 1'b1;
      end
      if (cap && lane_bad) begin
         cfg_d = 1'b1;
      end
      if (cap && !lane_bad && fifo_empty) begin
         udf_d = 1'b1;
      end

      if (do_cmp) begin
         done_d = 1'b1;
         err_d  = |mism;
         if (chk_cnt_q != CNT_MAX) begin
            chk_cnt_d = chk_cnt_q + CNT_WIDTH'(1);
         end
         if (|mism) begin
            if (err_cnt_q != CNT_MAX) begin
               err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
            end
            if (err_cnt_q == '0) begin
               fidx_d  = chk_cnt_q;
               felem_d = first_k;
            end
         end
      end

      if (clr) begin
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         level_d   = '0;
         done_d    = 1'b0;
         err_d     = 1'b0;
         chk_cnt_d = '0;
         err_cnt_d = '0;
         fidx_d    = '0;
         felem_d   = '0;
         ovf_d     = 1'b0;
         udf_d     = 1'b0;
         cfg_d     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         chk_cnt_q <= '0;
         err_cnt_q <= '0;
         fidx_q    <= '0;
         felem_q   <= '0;
         ovf_q     <= 1'b0;
         udf_q     <= 1'b0;
         cfg_q     <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         done_q    <= done_d;
         err_q     <= err_d;
         chk_cnt_q <= chk_cnt_d;
         err_cnt_q <= err_cnt_d;
         fidx_q    <= fidx_d;
         felem_q   <= felem_d;
         ovf_q     <= ovf_d;
         udf_q     <= udf_d;
         cfg_q     <= cfg_d;
      end
   end

   assign exp_full       = fifo_full;
   assign exp_level      = level_q;
   assign chk_done       = done_q;
   assign chk_err        = err_q;
   assign chk_cnt        = chk_cnt_q;
   assign err_cnt        = err_cnt_q;
   assign first_err_idx  = fidx_q;
   assign first_err_elem = felem_q;
   assign ovf            = ovf_q;
   assign udf            = udf_q;
   assign cfg_err        = cfg_q;

endmodule

// File: tb/tb_stream_ref_checker.sv
// tb/tb_stream_ref_checker.sv - directed vector bench for stream_ref_checker

module tb_stream_ref_checker;

   localparam int DW    = 8;
   localparam int NE    = 32;
   localparam int NL    = 12;   // not a power of two so lane_sel >= NUM_LANES is reachable
   localparam int FD    = 8;
   localparam int CD    = 1;
   localparam int CW    = 16;
   localparam int OBS_W = DW * NE;
   localparam int EXP_W = OBS_W * NL;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             clr = 1'b0;
   logic             exp_push = 1'b0;
   logic [EXP_W-1:0] exp_dat = '0;
   logic             exp_full;
   logic [3:0]       exp_level;
   logic             obs_trig = 1'b0;
   logic [OBS_W-1:0] obs_dat = '0;
   logic [NE-1:0]    obs_flg = '0;
   logic [3:0]       lane_sel = '0;
   logic             mode = 1'b0;
   logic             chk_done;
   logic             chk_err;
   logic [CW-1:0]    chk_cnt;
   logic [CW-1:0]    err_cnt;
   logic [CW-1:0]    first_err_idx;
   logic [4:0]       first_err_elem;
   logic             ovf;
   logic             udf;
   logic             cfg_err;

   stream_ref_checker #(
      .DATA_WIDTH(DW), .NUM_ELEM(NE), .NUM_LANES(NL),
      .FIFO_DEPTH(FD), .CAP_DELAY(CD), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .exp_push(exp_push), .exp_dat(exp_dat), .exp_full(exp_full), .exp_level(exp_level),
      .obs_trig(obs_trig), .obs_dat(obs_dat), .obs_flg(obs_flg), .lane_sel(lane_sel), .mode(mode),
      .chk_done(chk_done), .chk_err(chk_err), .chk_cnt(chk_cnt), .err_cnt(err_cnt),
      .first_err_idx(first_err_idx), .first_err_elem(first_err_elem),
      .ovf(ovf), .udf(udf), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      int          lane;
      logic        mode;
      logic [31:0] flg;
      logic [31:0] bad;
      logic        exp_err;
      int          exp_elem;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      n_chk++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   task automatic push_word(input logic [EXP_W-1:0] w);
      exp_push = 1'b1;
      exp_dat  = w;
      tick();
      exp_push = 1'b0;
   endtask

   // Trigger, then return just after the capture edge (CAP_DELAY = 1).
   task automatic trig_capture(input logic [OBS_W-1:0] o, input int lane, input logic m,
                               input logic [31:0] f);
      obs_dat  = o;
      lane_sel = 4'(lane);
      mode     = m;
      obs_flg  = f;
      obs_trig = 1'b1;
      tick();
      obs_trig = 1'b0;
      tick();
   endtask

   function automatic logic [OBS_W-1:0] lane_word(input int base);
      logic [OBS_W-1:0] w;
      w = '0;
      for (int k = 0; k < NE; k++) w[DW*k +: DW] = 8'(base + k + 1);
      return w;
   endfunction

   function automatic logic [EXP_W-1:0] exp_word(input int lane, input logic [OBS_W-1:0] w);
      logic [EXP_W-1:0] e;
      logic [7:0]       fill;
      e = '0;
      for (int l = 0; l < NL; l++) begin
         fill = 8'(8'h40 + l);
         e[OBS_W*(NL-1-l) +: OBS_W] = {NE{fill}};
      end
      e[OBS_W*(NL-1-lane) +: OBS_W] = w;
      return e;
   endfunction

   function automatic logic [OBS_W-1:0] corrupt(input logic [OBS_W-1:0] w, input logic [31:0] m);
      logic [OBS_W-1:0] r;
      r = w;
      for (int k = 0; k < NE; k++) if (m[k]) r[DW*k +: DW] = r[DW*k +: DW] ^ 8'hA5;
      return r;
   endfunction

   function automatic logic [EXP_W-1:0] fw(input int i);
      return exp_word(0, lane_word(i * 20));
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [OBS_W-1:0] ow;

      vecs[0]  = '{3,  1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 0};
      vecs[1]  = '{0,  1'b0, 32'h0000_0000, 32'h8000_0000, 1'b1, 31};
      vecs[2]  = '{11, 1'b0, 32'h0000_0000, 32'h0000_0001, 1'b1, 0};
      vecs[3]  = '{5,  1'b1, 32'h0000_000F, 32'hFFFF_FFF0, 1'b0, 0};
      vecs[4]  = '{5,  1'b1, 32'h0000_001F, 32'h0000_0010, 1'b1, 4};
      vecs[5]  = '{7,  1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 0};
      vecs[6]  = '{1,  1'b1, 32'h8000_0001, 32'h0000_0004, 1'b0, 0};
      vecs[7]  = '{1,  1'b1, 32'h8000_0001, 32'h0000_0002, 1'b1, 1};
      vecs[8]  = '{9,  1'b0, 32'h0000_0000, 32'h00F0_0000, 1'b1, 20};
      vecs[9]  = '{4,  1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 31};
      vecs[10] = '{6,  1'b0, 32'h0000_000F, 32'h0000_0100, 1'b1, 8};

      // Reset state
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("reset_outputs",
            {exp_full, exp_level, chk_done, chk_err, chk_cnt, err_cnt, ovf, udf, cfg_err}, '0);
      check("reset_first_err", {first_err_idx, first_err_elem}, '0);

      // Single-compare vector table
      for (int i = 0; i < 11; i++) begin
         do_clr();
         ow = lane_word(i * 3);
         push_word(exp_word(vecs[i].lane, ow));
         check($sformatf("vec%0d_level_push", i), exp_level, 1);
         trig_capture(corrupt(ow, vecs[i].bad), vecs[i].lane, vecs[i].mode, vecs[i].flg);
         check($sformatf("vec%0d_done", i), chk_done, 1);
         check($sformatf("vec%0d_err", i), chk_err, vecs[i].exp_err);
         check($sformatf("vec%0d_chk_cnt", i), chk_cnt, 1);
         check($sformatf("vec%0d_err_cnt", i), err_cnt, vecs[i].exp_err);
         check($sformatf("vec%0d_first_elem", i), first_err_elem,
               vecs[i].exp_err ? vecs[i].exp_elem : 0);
         check($sformatf("vec%0d_first_idx", i), first_err_idx, 0);
         check($sformatf("vec%0d_level_pop", i), exp_level, 0);
         tick();
         check($sformatf("vec%0d_pulse_end", i), {chk_done, chk_err}, 2'b00);
      end

      // Three back-to-back triggers, second observation corrupted at byte 5
      do_clr();
      push_word(exp_word(2, lane_word(0)));
      push_word(exp_word(2, lane_word(100)));
      push_word(exp_word(2, lane_word(150)));
      check("b2b_level", exp_level, 3);
      lane_sel = 4'd2;
      mode     = 1'b0;
      obs_trig = 1'b1;
      tick();
      obs_dat = lane_word(0);
      tick();
      check("b2b_c1", {chk_done, chk_err, chk_cnt}, {2'b10, 16'd1});
      obs_dat = corrupt(lane_word(100), 32'h0000_0020);
      tick();
      obs_trig = 1'b0;
      check("b2b_c2", {chk_done, chk_err, chk_cnt, err_cnt}, {2'b11, 16'd2, 16'd1});
      obs_dat = lane_word(150);
      tick();
      check("b2b_c3", {chk_done, chk_err, chk_cnt, err_cnt}, {2'b10, 16'd3, 16'd1});
      tick();
      check("b2b_idle", chk_done, 0);
      check("b2b_first", {first_err_idx, first_err_elem}, {16'd1, 5'd5});
      check("b2b_level_end", exp_level, 0);

      // FIFO fill, push+pop while full, overflow, drain in order
      do_clr();
      for (int i = 0; i < 8; i++) push_word(fw(i));
      check("fill_state", {exp_full, exp_level, ovf}, {1'b1, 4'd8, 1'b0});
      obs_dat  = lane_word(0);
      lane_sel = 4'd0;
      mode     = 1'b0;
      obs_trig = 1'b1;
      tick();
      obs_trig = 1'b0;
      exp_push = 1'b1;
      exp_dat  = fw(8);
      tick();
      exp_push = 1'b0;
      check("full_pushpop", {exp_full, exp_level, ovf, chk_done, chk_err},
            {1'b1, 4'd8, 1'b0, 1'b1, 1'b0});
      push_word(fw(9));
      check("ovf_drop", {ovf, exp_level}, {1'b1, 4'd8});
      for (int i = 1; i <= 8; i++) begin
         trig_capture(lane_word(i * 20), 0, 1'b0, 32'h0);
         check($sformatf("drain%0d", i), {chk_done, chk_err}, 2'b10);
      end
      check("drain_end", {exp_full, exp_level, chk_cnt, err_cnt}, {1'b0, 4'd0, 16'd9, 16'd0});

      // Lane index out of range: pops head, no compare
      do_clr();
      push_word(fw(0));
      trig_capture(lane_word(0), 12, 1'b0, 32'h0);
      check("cfg_pop", {cfg_err, udf, exp_level, chk_done, chk_cnt},
            {1'b1, 1'b0, 4'd0, 1'b0, 16'd0});
      do_clr();
      check("cfg_clr", cfg_err, 0);
      trig_capture(lane_word(0), 15, 1'b0, 32'h0);
      check("cfg_before_udf", {cfg_err, udf, chk_done}, 3'b100);

      // Underflow: same-cycle push is not bypassed
      do_clr();
      lane_sel = 4'd0;
      obs_dat  = lane_word(0);
      obs_trig = 1'b1;
      tick();
      obs_trig = 1'b0;
      exp_push = 1'b1;
      exp_dat  = fw(0);
      tick();
      exp_push = 1'b0;
      check("udf", {udf, cfg_err, chk_done, exp_level}, {1'b1, 1'b0, 1'b0, 4'd1});
      tick();
      check("udf_no_done", chk_done, 0);
      trig_capture(lane_word(0), 0, 1'b0, 32'h0);
      check("udf_after", {chk_done, chk_err, chk_cnt}, {2'b10, 16'd1});

      // Asynchronous reset with a capture pending
      push_word(fw(0));
      obs_trig = 1'b1;
      tick();
      obs_trig = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_async", {exp_full, exp_level, chk_done, chk_err, chk_cnt, err_cnt,
                          first_err_idx, first_err_elem, ovf, udf, cfg_err}, '0);
      tick();
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (chk_done) n++;
      end
      check("rst_no_done", n, 0);
      check("rst_level", exp_level, 0);

      // Synchronous clear with a capture pending
      push_word(fw(0));
      obs_trig = 1'b1;
      tick();
      obs_trig = 1'b0;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("clr_pending", {chk_done, exp_level, chk_cnt}, '0);
      tick();
      check("clr_no_done", chk_done, 0);

      // Error counter saturation: one mismatching compare per cycle
      do_clr();
      lane_sel = 4'd0;
      mode     = 1'b0;
      obs_dat  = corrupt(lane_word(0), 32'h0000_0001);
      exp_dat  = exp_word(0, lane_word(0));
      exp_push = 1'b1;
      obs_trig = 1'b1;
      n = 0;
      for (int i = 0; i < 65540; i++) begin
         tick();
         if (chk_err) n++;
      end
      exp_push = 1'b0;
      obs_trig = 1'b0;
      tick();
      if (chk_err) n++;
      tick();
      check("sat_pulses", n, 65540);
      check("sat_err_cnt", err_cnt, 16'hFFFF);
      check("sat_chk_cnt", chk_cnt, 16'hFFFF);
      check("sat_first", {first_err_idx, first_err_elem}, '0);
      check("sat_flags", {exp_level, ovf, udf, cfg_err}, '0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
